// File: rtl/archer_projectile_ctl_if.sv
// Bundle between the player/input logic, the projectile controller and the
// projectile draw stage. The master side drives archer state and fire input
// and consumes the packed projectile buses; the slave side is the controller.
interface archer_projectile_ctl_if #(
    parameter int PROJECTILE_COUNT = 4
);
    logic                            frame_tick;
    logic                            fire;
    logic [11:0]                     pos_x_archer;
    logic [11:0]                     pos_y_archer;
    logic                            flip_hor_archer;
    logic [1:0]                      game_active;
    logic [1:0]                      char_class;
    logic                            alive;
    logic [PROJECTILE_COUNT*12-1:0]  pos_x_proj;
    logic [PROJECTILE_COUNT*12-1:0]  pos_y_proj;
    logic [PROJECTILE_COUNT-1:0]     projectile_animated;
    logic [PROJECTILE_COUNT-1:0]     proj_dir;

    modport master (
        output frame_tick, fire, pos_x_archer, pos_y_archer, flip_hor_archer,
               game_active, char_class, alive,
        input  pos_x_proj, pos_y_proj, projectile_animated, proj_dir
    );

    modport slave (
        input  frame_tick, fire, pos_x_archer, pos_y_archer, flip_hor_archer,
               game_active, char_class, alive,
        output pos_x_proj, pos_y_proj, projectile_animated, proj_dir
    );
endinterface

// File: rtl/archer_projectile_ctl.sv
// Archer projectile controller: spawns projectiles at the archer on a fire
// request, moves them horizontally once per frame and retires them at the
// screen edge or at maximum lifetime. Produces packed per-slot X/Y buses, the
// active mask and the per-slot direction for the projectile draw stage.
//
// Optional feature macro: ARCHER_AUTOFIRE_EN
//   defined   - holding fire re-requests a spawn on every frame_tick with
//               cooldown 0 (one projectile per COOLDOWN_FRAMES+1 frames)
//   undefined - only rising edges of fire request a spawn
module archer_projectile_ctl #(
    parameter int PROJECTILE_COUNT = 4,
    parameter int PROJ_SPEED       = 6,
    parameter int COOLDOWN_FRAMES  = 15,
    parameter int MAX_FRAMES       = 120,
    parameter int SPAWN_OFFSET     = 20,
    parameter int SCREEN_W         = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    archer_projectile_ctl_if.slave bus
);
    localparam int LW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES + 1) : 1;
    localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [12:0]   SPEED13   = 13'(PROJ_SPEED);
    localparam logic [12:0]   EDGE13    = 13'(SCREEN_W - 1);
    localparam logic [12:0]   OFFS13    = 13'(SPAWN_OFFSET);
    localparam logic [LW-1:0] LIFE_MAX  = LW'(MAX_FRAMES);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_FRAMES);

    logic [11:0]                 x_q    [PROJECTILE_COUNT];
    logic [11:0]                 y_q    [PROJECTILE_COUNT];
    logic [LW-1:0]               life_q [PROJECTILE_COUNT];
    logic [PROJECTILE_COUNT-1:0] act_q;
    logic [PROJECTILE_COUNT-1:0] dir_q;
    logic [CW-1:0]               cool_q;
    logic                        pend_q;
    logic                        fire_q;

    logic                        enable;
    logic                        fire_rise;
    logic                        autofire_req;
    logic                        pend_eff;
    logic                        spawn;
    logic [PROJECTILE_COUNT-1:0] spawn_sel;
    logic [11:0]                 spawn_x;
    logic [11:0]                 x_next [PROJECTILE_COUNT];
    logic [LW-1:0]               life_inc [PROJECTILE_COUNT];
    logic [PROJECTILE_COUNT-1:0] retire;

    assign enable    = (bus.game_active != 2'd0) && (bus.char_class == 2'd2) && bus.alive;
    assign fire_rise = bus.fire && !fire_q;

`ifdef ARCHER_AUTOFIRE_EN
    assign autofire_req = bus.fire && (cool_q == '0);
`else
    assign autofire_req = 1'b0;
`endif

    // A rising edge on the tick cycle itself counts as already pending.
    assign pend_eff = pend_q || fire_rise || autofire_req;
    assign spawn    = bus.frame_tick && pend_eff && (cool_q == '0) && (spawn_sel != '0);

    // Lowest-index free slot, judged on the mask at the start of the cycle so a
    // slot retiring this tick cannot be reused until the next tick.
    always_comb begin
        logic found;
        found     = 1'b0;
        spawn_sel = '0;
        for (int i = 0; i < PROJECTILE_COUNT; i++) begin
            if (!act_q[i] && !found) begin
                spawn_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // Spawn point beside the archer; saturates at 0 when facing left near the edge.
    always_comb begin
        logic [12:0] pos_x13;
        pos_x13 = {1'b0, bus.pos_x_archer};
        if (bus.flip_hor_archer)
            spawn_x = (pos_x13 < OFFS13) ? 12'd0 : 12'(pos_x13 - OFFS13);
        else
            spawn_x = 12'(pos_x13 + OFFS13);
    end

    // Per-slot next position and retire decision; right edge compared in 13 bits so it cannot wrap.
    always_comb begin
        for (int i = 0; i < PROJECTILE_COUNT; i++) begin
            logic [12:0] x_ext;
            logic        hit;
            x_ext       = {1'b0, x_q[i]};
            life_inc[i] = life_q[i] + LW'(1);
            if (dir_q[i]) begin
                hit       = x_ext < SPEED13;
                x_next[i] = x_q[i] - 12'(PROJ_SPEED);
            end else begin
                hit       = (x_ext + SPEED13) > EDGE13;
                x_next[i] = 12'(x_ext + SPEED13);
            end
            retire[i] = (life_inc[i] == LIFE_MAX) || hit;
        end
    end

    // Fire capture, cooldown and slot state; everything but fire capture advances only on frame_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_q <= 1'b0;
            pend_q <= 1'b0;
            cool_q <= '0;
            act_q  <= '0;
            dir_q  <= '0;
            for (int i = 0; i < PROJECTILE_COUNT; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                life_q[i] <= '0;
            end
        end else begin
            fire_q <= bus.fire;
            if (!enable) begin
                pend_q <= 1'b0;
                cool_q <= '0;
                act_q  <= '0;
                dir_q  <= '0;
                for (int i = 0; i < PROJECTILE_COUNT; i++) begin
                    x_q[i]    <= '0;
                    y_q[i]    <= '0;
                    life_q[i] <= '0;
                end
            end else if (!bus.frame_tick) begin
                if (fire_rise)
                    pend_q <= 1'b1;
            end else begin
                pend_q <= spawn ? 1'b0 : pend_eff;
                if (spawn)
                    cool_q <= COOL_LOAD;
                else if (cool_q != '0)
                    cool_q <= cool_q - CW'(1);
                for (int i = 0; i < PROJECTILE_COUNT; i++) begin
                    if (act_q[i]) begin
                        if (retire[i]) begin
                            act_q[i]  <= 1'b0;
                            dir_q[i]  <= 1'b0;
                            x_q[i]    <= '0;
                            y_q[i]    <= '0;
                            life_q[i] <= '0;
                        end else begin
                            x_q[i]    <= x_next[i];
                            life_q[i] <= life_inc[i];
                        end
                    end else if (spawn && spawn_sel[i]) begin
                        act_q[i]  <= 1'b1;
                        dir_q[i]  <= bus.flip_hor_archer;
                        x_q[i]    <= spawn_x;
                        y_q[i]    <= bus.pos_y_archer;
                        life_q[i] <= '0;
                    end
                end
            end
        end
    end

    // Pack slot registers onto the draw-stage buses.
    for (genvar g = 0; g < PROJECTILE_COUNT; g++) begin : g_pack
        assign bus.pos_x_proj[g*12 +: 12] = x_q[g];
        assign bus.pos_y_proj[g*12 +: 12] = y_q[g];
    end
    assign bus.projectile_animated = act_q;
    assign bus.proj_dir            = dir_q;
endmodule

// File: tb/tb_archer_projectile_ctl.sv
// Directed bench for archer_projectile_ctl. A second instance with zero speed
// shares the same stimulus and is used for the lifetime-retire case.
module tb_archer_projectile_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick_cnt = 0;

    always #5 clk = ~clk;

    archer_projectile_ctl_if #(.PROJECTILE_COUNT(4)) bus ();
    archer_projectile_ctl_if #(.PROJECTILE_COUNT(4)) bus2 ();

    assign bus2.frame_tick      = bus.frame_tick;
    assign bus2.fire            = bus.fire;
    assign bus2.pos_x_archer    = bus.pos_x_archer;
    assign bus2.pos_y_archer    = bus.pos_y_archer;
    assign bus2.flip_hor_archer = bus.flip_hor_archer;
    assign bus2.game_active     = bus.game_active;
    assign bus2.char_class      = bus.char_class;
    assign bus2.alive           = bus.alive;

    archer_projectile_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    archer_projectile_ctl #(.PROJ_SPEED(0)) dut_slow (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Compare one observed value against its hand-computed expectation.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] px(input int i);
        return bus.pos_x_proj[i*12 +: 12];
    endfunction

    function automatic logic [11:0] py(input int i);
        return bus.pos_y_proj[i*12 +: 12];
    endfunction

    task automatic do_tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        tick_cnt++;
    endtask

    task automatic fire_pulse();
        @(negedge clk);
        bus.fire = 1'b1;
        @(negedge clk);
        bus.fire = 1'b0;
    endtask

    task automatic ticks_until(input int target);
        while (tick_cnt < target) do_tick();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick_cnt = 0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.frame_tick      = 1'b0;
        bus.fire            = 1'b0;
        bus.pos_x_archer    = 12'd500;
        bus.pos_y_archer    = 12'd300;
        bus.flip_hor_archer = 1'b0;
        bus.game_active     = 2'd1;
        bus.char_class      = 2'd2;
        bus.alive           = 1'b1;

        // Reset state
        apply_reset();
        check_val("rst_mask", bus.projectile_animated, 0);
        check_val("rst_x",    bus.pos_x_proj, 0);
        check_val("rst_y",    bus.pos_y_proj, 0);
        check_val("rst_dir",  bus.proj_dir, 0);

        // First spawn to the right, then one move
        fire_pulse();
        do_tick();
        tick_cnt = 0;
        check_val("spawn_mask", bus.projectile_animated, 4'b0001);
        check_val("spawn_x",    px(0), 520);
        check_val("spawn_y",    py(0), 300);
        check_val("spawn_dir",  bus.proj_dir, 0);
        do_tick();
        check_val("move_x", px(0), 526);

        // Second fire waits out cooldown: spawns on tick 16 into slot1
        fire_pulse();
        ticks_until(15);
        check_val("cool_t15_mask", bus.projectile_animated, 4'b0001);
        do_tick();
        check_val("cool_t16_mask", bus.projectile_animated, 4'b0011);
        check_val("cool_t16_x1",   px(1), 520);
        check_val("cool_t16_x0",   px(0), 616);

        // Fill all slots, then a fifth request waits for slot0 to retire at the edge
        fire_pulse();
        ticks_until(32);
        check_val("fill3_mask", bus.projectile_animated, 4'b0111);
        fire_pulse();
        ticks_until(48);
        check_val("fill4_mask", bus.projectile_animated, 4'b1111);
        fire_pulse();
        ticks_until(83);
        check_val("full_t83_x0", px(0), 1018);
        do_tick();
        check_val("full_t84_mask", bus.projectile_animated, 4'b1110);
        check_val("full_t84_x0",   px(0), 0);
        do_tick();
        check_val("full_t85_mask", bus.projectile_animated, 4'b1111);
        check_val("full_t85_x0",   px(0), 520);

        // Left spawn saturates at 0, then retires next tick
        apply_reset();
        bus.flip_hor_archer = 1'b1;
        bus.pos_x_archer    = 12'd10;
        bus.pos_y_archer    = 12'd50;
        fire_pulse();
        do_tick();
        check_val("left_mask", bus.projectile_animated, 4'b0001);
        check_val("left_x",    px(0), 0);
        check_val("left_dir",  bus.proj_dir, 4'b0001);
        do_tick();
        check_val("left_ret_mask", bus.projectile_animated, 0);
        check_val("left_ret_x",    px(0), 0);

        // Right edge: 1015 -> 1021 -> retire (no wrap)
        apply_reset();
        bus.flip_hor_archer = 1'b0;
        bus.pos_x_archer    = 12'd995;
        fire_pulse();
        do_tick();
        check_val("edge_spawn_x", px(0), 1015);
        do_tick();
        check_val("edge_x1", px(0), 1021);
        do_tick();
        check_val("edge_ret_mask", bus.projectile_animated, 0);
        check_val("edge_ret_x",    px(0), 0);

        // Exact fit: 1017 -> 1023 stays alive, then retires
        apply_reset();
        bus.pos_x_archer = 12'd997;
        fire_pulse();
        do_tick();
        do_tick();
        check_val("fit_x",    px(0), 1023);
        check_val("fit_mask", bus.projectile_animated, 4'b0001);
        do_tick();
        check_val("fit_ret_mask", bus.projectile_animated, 0);

        // Rising edge on the tick cycle spawns at once; holding fire gives one shot only
        apply_reset();
        bus.pos_x_archer = 12'd200;
        @(negedge clk);
        bus.fire       = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        check_val("same_cyc_mask", bus.projectile_animated, 4'b0001);
        tick_cnt = 0;
        ticks_until(20);
        check_val("held_mask", bus.projectile_animated, 4'b0001);
        bus.fire = 1'b0;

        // Class change clears everything including a pending fire
        apply_reset();
        bus.flip_hor_archer = 1'b1;
        bus.pos_x_archer    = 12'd600;
        fire_pulse();
        do_tick();
        tick_cnt = 0;
        fire_pulse();
        ticks_until(16);
        fire_pulse();
        ticks_until(32);
        check_val("cls_pre_mask", bus.projectile_animated, 4'b0111);
        check_val("cls_pre_dir",  bus.proj_dir, 4'b0111);
        fire_pulse();
        @(negedge clk);
        bus.char_class = 2'd1;
        @(negedge clk);
        check_val("cls_mask", bus.projectile_animated, 0);
        check_val("cls_x",    bus.pos_x_proj, 0);
        check_val("cls_y",    bus.pos_y_proj, 0);
        check_val("cls_dir",  bus.proj_dir, 0);
        bus.char_class = 2'd2;
        do_tick();
        check_val("cls_no_pend", bus.projectile_animated, 0);

        // Lifetime retire on the zero-speed instance
        apply_reset();
        bus.flip_hor_archer = 1'b0;
        bus.pos_x_archer    = 12'd100;
        bus.pos_y_archer    = 12'd40;
        fire_pulse();
        do_tick();
        tick_cnt = 0;
        check_val("life_spawn_x", bus2.pos_x_proj[11:0], 120);
        ticks_until(119);
        check_val("life_t119_mask", bus2.projectile_animated, 4'b0001);
        check_val("life_t119_x",    bus2.pos_x_proj[11:0], 120);
        do_tick();
        check_val("life_t120_mask", bus2.projectile_animated, 0);
        check_val("life_t120_fast", bus.projectile_animated, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
